// File: rtl/axi_burst_write_feeder.sv
// axi_burst_write_feeder
// Buffers a 64-bit valid/ready stream in a local FIFO and cuts one job
// (base address, beat count) into INCR bursts of at most MAX_BURST beats,
// driving the AXI burst master's user write port burst by burst.
// Optional feature macro: WRFEED_4K_SPLIT_EN -- when defined, no burst is
// allowed to cross a 4 KB address boundary.
module axi_burst_write_feeder #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 64,
    parameter int MAX_BURST  = 16,
    parameter int FIFO_DEPTH = 32
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic [ADDR_W-1:0]     cfg_base_addr,
    input  logic [15:0]           cfg_beats,
    input  logic                  cfg_start,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    input  logic [DATA_W-1:0]     s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic                  user_start,
    input  logic                  user_free,
    output logic [ADDR_W-1:0]     user_addr_in,
    output logic [7:0]            user_burst_len_in,
    output logic [DATA_W-1:0]     user_data_in,
    output logic [DATA_W/8-1:0]   user_data_strb,
    output logic                  user_w_r,
    input  logic                  user_stall_w_data,
    input  logic [1:0]            user_status
);

    localparam int BYTES = DATA_W / 8;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int N_W   = $clog2(MAX_BURST + 1);

    typedef enum logic [2:0] {
        IDLE,
        CALC,
        FILL,
        REQ,
        DATA,
        DRAIN,
        FIN
    } state_e;

    state_e              state_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [15:0]         left_q;
    logic [N_W-1:0]      n_q;
    logic [N_W-1:0]      beat_q;
    logic                saw_low_q;
    logic                busy_q;
    logic                done_q;
    logic                err_q;
    logic                start_q;
    logic [ADDR_W-1:0]   uaddr_q;
    logic [7:0]          ulen_q;

    // FIFO storage and bookkeeping
    logic [DATA_W-1:0]   mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q;
    logic [PTR_W-1:0]    rd_ptr_q;
    logic [CNT_W-1:0]    count_q;
    logic [CNT_W-1:0]    count_d;
    logic                fifo_full;
    logic                fifo_empty;
    logic                push;
    logic                pop;
    logic [N_W-1:0]      n_calc;

    assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
    assign fifo_empty = (count_q == '0);
    assign push       = s_valid && s_ready;
    assign pop        = (state_q == DATA) && !user_stall_w_data && !fifo_empty;

    assign busy              = busy_q;
    assign done              = done_q;
    assign err               = err_q;
    assign s_ready           = busy_q && !fifo_full;
    assign user_start        = start_q;
    assign user_addr_in      = uaddr_q;
    assign user_burst_len_in = ulen_q;
    assign user_data_in      = fifo_empty ? '0 : mem_q[rd_ptr_q];
    assign user_data_strb    = {BYTES{busy_q}};
    assign user_w_r          = 1'b0;

`ifdef WRFEED_4K_SPLIT_EN
    // Beats remaining before the next 4 KB boundary (1..4096/BYTES).
    logic [12:0] to_4k;
    assign to_4k = (13'd4096 - {1'b0, addr_q[11:0]}) / 13'(BYTES);
`endif

    // Size of the next burst: the smallest of remaining beats, MAX_BURST
    // and (optionally) the distance to the next 4 KB boundary.
    always_comb begin
        // NOTE: default assignment first keeps this block combinational and latch-free.
        n_calc = N_W'(MAX_BURST);
        if (left_q < 16'(MAX_BURST)) begin
            n_calc = N_W'(left_q);
        end
`ifdef WRFEED_4K_SPLIT_EN
        if (to_4k < 13'(n_calc)) begin
            n_calc = N_W'(to_4k);
        end
`endif
    end

    // FIFO occupancy; simultaneous push and pop leave it unchanged.
    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // FIFO data array write port.
    always_ff @(posedge aclk) begin
        // NOTE: the storage array has no reset; pointers and count define which
        // entries are valid, and the read mux forces 0 while the FIFO is empty.
        if (push) begin
            mem_q[wr_ptr_q] <= s_data;
        end
    end

    // FIFO pointers and count; reset flushes the FIFO.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_d;
        end
    end

    // Job sequencer: splits the job into bursts and handshakes with the master.
    always_ff @(posedge aclk or negedge aresetn) begin
        // NOTE: non-blocking assignments so every register updates from pre-edge values.
        if (!aresetn) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            left_q    <= '0;
            n_q       <= '0;
            beat_q    <= '0;
            saw_low_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            start_q   <= 1'b0;
            uaddr_q   <= '0;
            ulen_q    <= '0;
        end else begin
            done_q  <= 1'b0;
            start_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cfg_start) begin
                        addr_q  <= cfg_base_addr;
                        left_q  <= cfg_beats;
                        err_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= (cfg_beats == 16'd0) ? FIN : CALC;
                    end
                end
                CALC: begin
                    n_q     <= n_calc;
                    beat_q  <= '0;
                    state_q <= FILL;
                end
                FILL: begin
                    // The whole burst must be buffered so the data phase never starves.
                    if (count_q >= CNT_W'(n_q)) begin
                        state_q <= REQ;
                    end
                end
                REQ: begin
                    if (user_free) begin
                        start_q   <= 1'b1;
                        uaddr_q   <= addr_q;
                        ulen_q    <= 8'(n_q) - 8'd1;
                        saw_low_q <= 1'b0;
                        state_q   <= DATA;
                    end
                end
                DATA: begin
                    // The master drops user_free one cycle late; remember having seen it.
                    if (!user_free) begin
                        saw_low_q <= 1'b1;
                    end
                    if (pop) begin
                        beat_q <= beat_q + N_W'(1);
                        if (beat_q == n_q - N_W'(1)) begin
                            state_q <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (!user_free) begin
                        saw_low_q <= 1'b1;
                    end else if (saw_low_q) begin
                        if (user_status != 2'd0) begin
                            err_q <= 1'b1;
                        end
                        addr_q  <= addr_q + ADDR_W'(n_q) * ADDR_W'(BYTES);
                        left_q  <= left_q - 16'(n_q);
                        state_q <= (left_q == 16'(n_q)) ? FIN : CALC;
                    end
                end
                FIN: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // The data phase only starts with a full burst buffered, so it never pops an empty FIFO.
    a_no_empty_pop: assert property (@(posedge aclk) disable iff (!aresetn)
        (state_q == DATA && !user_stall_w_data) |-> !fifo_empty);

endmodule

// File: tb/tb_axi_burst_write_feeder.sv
// Self-checking bench for axi_burst_write_feeder: a behavioural master and
// stream source drive random traffic; bursts and popped data are compared
// against a burst-splitting model and the sequence of words sent.
`timescale 1ns/1ps
module tb_axi_burst_write_feeder;

    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 64;
    localparam int MAX_BURST  = 16;
    localparam int FIFO_DEPTH = 32;
    localparam int BYTES      = DATA_W / 8;

    logic                aclk = 1'b0;
    logic                aresetn = 1'b0;
    logic [ADDR_W-1:0]   cfg_base_addr = '0;
    logic [15:0]         cfg_beats = '0;
    logic                cfg_start = 1'b0;
    logic                busy, done, err;
    logic [DATA_W-1:0]   s_data = '0;
    logic                s_valid = 1'b0;
    logic                s_ready;
    logic                user_start;
    logic                user_free = 1'b1;
    logic [ADDR_W-1:0]   user_addr_in;
    logic [7:0]          user_burst_len_in;
    logic [DATA_W-1:0]   user_data_in;
    logic [BYTES-1:0]    user_data_strb;
    logic                user_w_r;
    logic                user_stall_w_data = 1'b0;
    logic [1:0]          user_status = 2'd0;

    always #5 aclk = ~aclk;

    axi_burst_write_feeder #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BURST(MAX_BURST), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .aclk(aclk), .aresetn(aresetn),
        .cfg_base_addr(cfg_base_addr), .cfg_beats(cfg_beats), .cfg_start(cfg_start),
        .busy(busy), .done(done), .err(err),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .user_start(user_start), .user_free(user_free),
        .user_addr_in(user_addr_in), .user_burst_len_in(user_burst_len_in),
        .user_data_in(user_data_in), .user_data_strb(user_data_strb),
        .user_w_r(user_w_r), .user_stall_w_data(user_stall_w_data),
        .user_status(user_status)
    );

    int checks = 0;
    int failures = 0;

    // Results of the most recent job
    logic [ADDR_W-1:0] got_addr[$];
    int                got_len[$];
    logic [DATA_W-1:0] got_data[$];
    logic [DATA_W-1:0] sent[$];
    logic [ADDR_W-1:0] exp_addr[$];
    int                exp_len[$];
    int                status_plan[$];
    int done_cnt, done_cyc, last_raise_cyc, pushed_at_first_start, bad_start;
    logic busy_c0, busy_c1, err_c1, err_done;

    // Expected burst list from the job rules: n = min(left, MAX_BURST[, beats to 4 KB]).
    function automatic void build_model(input logic [ADDR_W-1:0] base, input int beats);
        logic [ADDR_W-1:0] a;
        int left, n, to4k;
        a = base;
        left = beats;
        exp_addr.delete();
        exp_len.delete();
        while (left > 0) begin
            n = (left < MAX_BURST) ? left : MAX_BURST;
`ifdef WRFEED_4K_SPLIT_EN
            to4k = (4096 - int'(a % 4096)) / BYTES;
            if (to4k < n) n = to4k;
`else
            to4k = 0;
`endif
            exp_addr.push_back(a);
            exp_len.push_back(n - 1);
            a = a + ADDR_W'(n * BYTES);
            left -= n;
        end
    endfunction

    // Launch one job and play master + source until done (or abort/timeout).
    // src_mode: 0 continuous, 1 every 4th cycle, 2 random.
    // stall_mode: 0 none, 1 one on / two off, 2 random.
    task automatic run_job(input logic [ADDR_W-1:0] base, input int beats,
                           input int src_mode, input int stall_mode, input int abort_pops);
        int idx, data_left, hold, bursts, scnt, cyc;
        bit drop_next, fin, stall, en, saw_start;
        idx = 0; data_left = 0; hold = 0; bursts = 0; scnt = 0; cyc = 0;
        drop_next = 0; fin = 0;
        sent.delete(); got_addr.delete(); got_len.delete(); got_data.delete();
        for (int i = 0; i < beats; i++) sent.push_back({$urandom, $urandom});
        done_cnt = 0; done_cyc = -1; last_raise_cyc = -1; pushed_at_first_start = -1; bad_start = 0;
        @(negedge aclk);
        busy_c0 = busy;
        cfg_base_addr = base;
        cfg_beats = 16'(beats);
        cfg_start = 1'b1;
        while (!fin) begin
            @(negedge aclk);
            cyc++;
            cfg_start = 1'b0;
            // Sample DUT outputs
            if (cyc == 1) begin busy_c1 = busy; err_c1 = err; end
            if (done) begin done_cnt++; done_cyc = cyc; err_done = err; fin = 1; end
            saw_start = user_start;
            if (user_start && !user_free) bad_start++;
            // Master: free drops one cycle after start, rises after the data is taken
            if (drop_next) begin
                user_free = 1'b0;
                drop_next = 0;
                hold = $urandom_range(0, 3);
            end else if (!user_free && data_left == 0) begin
                if (hold == 0) begin
                    user_status = (bursts - 1 < status_plan.size()) ? 2'(status_plan[bursts-1]) : 2'd0;
                    user_free = 1'b1;
                    last_raise_cyc = cyc;
                end else begin
                    hold--;
                end
            end
            if (saw_start) begin
                got_addr.push_back(user_addr_in);
                got_len.push_back(int'(user_burst_len_in));
                if (bursts == 0) pushed_at_first_start = idx;
                bursts++;
                data_left = int'(user_burst_len_in) + 1;
                drop_next = 1;
                scnt = 0;
            end
            // Master data phase: a word is taken on each edge with stall low
            if (data_left > 0) begin
                case (stall_mode)
                    0: stall = 0;
                    1: stall = (scnt % 3 == 0);
                    default: stall = 1'($urandom_range(0, 1));
                endcase
                scnt++;
                user_stall_w_data = stall;
                if (!stall) begin
                    got_data.push_back(user_data_in);
                    data_left--;
                end
            end else begin
                user_stall_w_data = 1'b0;
            end
            // Stream source
            if (idx < beats) begin
                case (src_mode)
                    0: en = 1;
                    1: en = (cyc % 4 == 0);
                    default: en = 1'($urandom_range(0, 1));
                endcase
                s_valid = en;
                s_data = sent[idx];
                if (en && s_ready) idx++;
            end else begin
                s_valid = 1'b0;
            end
            if (abort_pops > 0 && got_data.size() >= abort_pops) fin = 1;
            if (!fin && cyc > 4000) begin
                checks++; failures++;
                $display("FAIL job_timeout: no done after %0d cycles, required done", cyc);
                fin = 1;
            end
        end
        s_valid = 1'b0;
        user_stall_w_data = 1'b0;
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        repeat (3) @(negedge aclk);
        checks++;
        if ({busy, done, err, s_ready, user_start, user_w_r} !== 6'b0) begin
            failures++;
            $display("FAIL reset_ctrl: got %b, required 000000", {busy, done, err, s_ready, user_start, user_w_r});
        end
        checks++;
        if (user_addr_in !== '0 || user_burst_len_in !== 8'd0 || user_data_strb !== '0 || user_data_in !== '0) begin
            failures++;
            $display("FAIL reset_data: addr %h len %h strb %h data %h, required all 0",
                     user_addr_in, user_burst_len_in, user_data_strb, user_data_in);
        end
        aresetn = 1'b1;
        @(negedge aclk);
    endtask

    task automatic test_basic();
        status_plan = '{0, 0, 0};
        run_job(32'h1000_0000, 40, 0, 0, 0);
        build_model(32'h1000_0000, 40);
        checks++;
        if (got_addr.size() !== 3 || exp_addr.size() !== 3) begin
            failures++;
            $display("FAIL basic_burst_count: got %0d, required 3", got_addr.size());
        end
        for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++) begin
            checks++;
            if (got_addr[i] !== exp_addr[i] || got_len[i] !== exp_len[i]) begin
                failures++;
                $display("FAIL basic_burst%0d: got %h/len %0d, required %h/len %0d",
                         i, got_addr[i], got_len[i], exp_addr[i], exp_len[i]);
            end
        end
        checks++;
        if (got_data.size() !== 40) begin
            failures++;
            $display("FAIL basic_pop_count: got %0d, required 40", got_data.size());
        end
        for (int i = 0; i < 40 && i < got_data.size(); i++) begin
            checks++;
            if (got_data[i] !== sent[i]) begin
                failures++;
                $display("FAIL basic_data%0d: got %h, required %h", i, got_data[i], sent[i]);
            end
        end
        checks++;
        if (busy_c0 !== 1'b0 || busy_c1 !== 1'b1) begin
            failures++;
            $display("FAIL basic_busy_rise: got before=%b after=%b, required 0/1", busy_c0, busy_c1);
        end
        checks++;
        if (done_cnt !== 1 || err_done !== 1'b0) begin
            failures++;
            $display("FAIL basic_done_err: done %0d err %b, required 1/0", done_cnt, err_done);
        end
        checks++;
        if (done_cyc !== last_raise_cyc + 2) begin
            failures++;
            $display("FAIL basic_done_timing: done at %0d, required %0d", done_cyc, last_raise_cyc + 2);
        end
        checks++;
        if (bad_start !== 0) begin
            failures++;
            $display("FAIL basic_start_while_busy: got %0d, required 0", bad_start);
        end
        @(negedge aclk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL basic_done_pulse: done %b busy %b one cycle later, required 0/0", done, busy);
        end
    endtask

    task automatic test_4k_split();
        int want;
`ifdef WRFEED_4K_SPLIT_EN
        want = 2;
`else
        want = 1;
`endif
        status_plan = '{0, 0};
        run_job(32'h1000_0FC0, 16, 0, 0, 0);
        build_model(32'h1000_0FC0, 16);
        checks++;
        if (got_addr.size() !== want) begin
            failures++;
            $display("FAIL split_burst_count: got %0d, required %0d", got_addr.size(), want);
        end
        for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++) begin
            checks++;
            if (got_addr[i] !== exp_addr[i] || got_len[i] !== exp_len[i]) begin
                failures++;
                $display("FAIL split_burst%0d: got %h/len %0d, required %h/len %0d",
                         i, got_addr[i], got_len[i], exp_addr[i], exp_len[i]);
            end
        end
    endtask

    task automatic test_stalls();
        status_plan = '{0, 0, 0};
        run_job(32'h0000_4000, 40, 0, 1, 0);
        checks++;
        if (got_data.size() !== 40) begin
            failures++;
            $display("FAIL stall_pop_count: got %0d, required 40", got_data.size());
        end
        for (int i = 0; i < 40 && i < got_data.size(); i++) begin
            checks++;
            if (got_data[i] !== sent[i]) begin
                failures++;
                $display("FAIL stall_data%0d: got %h, required %h", i, got_data[i], sent[i]);
            end
        end
    endtask

    task automatic test_slow_source();
        status_plan = '{0, 0};
        run_job(32'h2000_0000, 20, 1, 0, 0);
        checks++;
        if (pushed_at_first_start < 16) begin
            failures++;
            $display("FAIL slow_first_start: %0d words buffered at start, required >= 16", pushed_at_first_start);
        end
        for (int i = 0; i < 20; i++) begin
            checks++;
            if (i >= got_data.size() || got_data[i] !== sent[i]) begin
                failures++;
                $display("FAIL slow_data%0d: got %h, required %h", i,
                         (i < got_data.size()) ? got_data[i] : '0, sent[i]);
            end
        end
    endtask

    task automatic test_error();
        status_plan = '{0, 2, 0};
        run_job(32'h3000_0000, 40, 0, 0, 0);
        checks++;
        if (got_addr.size() !== 3 || err_done !== 1'b1) begin
            failures++;
            $display("FAIL error_job: bursts %0d err %b, required 3/1", got_addr.size(), err_done);
        end
        repeat (2) @(negedge aclk);
        checks++;
        if (err !== 1'b1) begin
            failures++;
            $display("FAIL error_sticky: err %b after job, required 1", err);
        end
        status_plan = '{0, 0};
        run_job(32'h3000_1000, 20, 0, 0, 0);
        checks++;
        if (err_c1 !== 1'b0 || err_done !== 1'b0) begin
            failures++;
            $display("FAIL error_clear: err after start %b at done %b, required 0/0", err_c1, err_done);
        end
    endtask

    task automatic test_zero_beats();
        status_plan.delete();
        run_job(32'h4000_0000, 0, 0, 0, 0);
        checks++;
        if (done_cyc !== 2 || busy_c1 !== 1'b1) begin
            failures++;
            $display("FAIL zero_done: done at cycle %0d busy %b, required 2/1", done_cyc, busy_c1);
        end
        checks++;
        if (got_addr.size() !== 0) begin
            failures++;
            $display("FAIL zero_no_start: %0d bursts, required 0", got_addr.size());
        end
    endtask

    task automatic test_reset_mid_job();
        status_plan = '{0, 0, 0};
        run_job(32'h5000_0000, 40, 0, 0, 3);
        #2;
        aresetn = 1'b0;
        #1;
        checks++;
        if ({busy, done, err, s_ready, user_start} !== 5'b0 || user_addr_in !== '0 ||
            user_burst_len_in !== 8'd0 || user_data_strb !== '0 || user_data_in !== '0) begin
            failures++;
            $display("FAIL midreset_outputs: ctrl %b addr %h len %h strb %h data %h, required all 0",
                     {busy, done, err, s_ready, user_start}, user_addr_in, user_burst_len_in,
                     user_data_strb, user_data_in);
        end
        user_free = 1'b1;
        user_stall_w_data = 1'b0;
        user_status = 2'd0;
        s_valid = 1'b0;
        repeat (2) @(negedge aclk);
        aresetn = 1'b1;
        run_job(32'h5000_0800, 24, 0, 0, 0);
        checks++;
        if (got_data.size() !== 24 || done_cnt !== 1) begin
            failures++;
            $display("FAIL midreset_recover: pops %0d done %0d, required 24/1", got_data.size(), done_cnt);
        end
        for (int i = 0; i < 24 && i < got_data.size(); i++) begin
            checks++;
            if (got_data[i] !== sent[i]) begin
                failures++;
                $display("FAIL midreset_data%0d: got %h, required %h", i, got_data[i], sent[i]);
            end
        end
    endtask

    task automatic test_random();
        logic [ADDR_W-1:0] base;
        int beats;
        bit want_err;
        for (int j = 0; j < 6; j++) begin
            base = ADDR_W'($urandom) & ~ADDR_W'(BYTES - 1);
            beats = $urandom_range(1, 60);
            build_model(base, beats);
            status_plan.delete();
            want_err = 0;
            for (int k = 0; k < exp_addr.size(); k++) begin
                status_plan.push_back(($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
                if (status_plan[k] != 0) want_err = 1;
            end
            run_job(base, beats, $urandom_range(0, 2), $urandom_range(0, 2), 0);
            checks++;
            if (got_addr.size() !== exp_addr.size()) begin
                failures++;
                $display("FAIL rand%0d_burst_count: got %0d, required %0d", j, got_addr.size(), exp_addr.size());
            end
            for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++) begin
                checks++;
                if (got_addr[i] !== exp_addr[i] || got_len[i] !== exp_len[i]) begin
                    failures++;
                    $display("FAIL rand%0d_burst%0d: got %h/len %0d, required %h/len %0d",
                             j, i, got_addr[i], got_len[i], exp_addr[i], exp_len[i]);
                end
            end
            for (int i = 0; i < beats; i++) begin
                checks++;
                if (i >= got_data.size() || got_data[i] !== sent[i]) begin
                    failures++;
                    $display("FAIL rand%0d_data%0d: got %h, required %h", j, i,
                             (i < got_data.size()) ? got_data[i] : '0, sent[i]);
                end
            end
            checks++;
            if (done_cnt !== 1 || err_done !== want_err || bad_start !== 0) begin
                failures++;
                $display("FAIL rand%0d_status: done %0d err %b badstart %0d, required 1/%b/0",
                         j, done_cnt, err_done, bad_start, want_err);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_4k_split();
        test_stalls();
        test_slow_source();
        test_error();
        test_zero_beats();
        test_reset_mid_job();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule

// File: doc/axi_burst_write_feeder.md
# axi_burst_write_feeder

Upstream stage of the AXI burst master's user write port. Accepts a valid/ready stream of 64-bit words plus a job descriptor (base address, total beat count). Buffers the words in a local FIFO and cuts the job into INCR bursts of at most MAX_BURST beats. It then drives the master's start/address/length/strobe/data inputs burst by burst, and reports completion and error status for the whole job.

## Interface
Parameters:
- ADDR_W, 32, address width.
- DATA_W, 64, data width; byte-addressed, beat size DATA_W/8 bytes.
- MAX_BURST, 16, maximum beats per burst (1..16).
- FIFO_DEPTH, 32, data FIFO entries; power of two, at least MAX_BURST.

Ports:
- aclk  in  1  clock; all logic on its rising edge.
- aresetn  in  1  asynchronous active-low reset.
- cfg_base_addr  in  ADDR_W  job start address; must be beat-aligned.
- cfg_beats  in  16  total beats in the job.
- cfg_start  in  1  one-cycle job launch; ignored while busy=1.
- busy  out  1  job in progress.
- done  out  1  one-cycle pulse when the job completes.
- err  out  1  sticky for the job; set if any burst ends with user_status != 0; cleared on cfg_start.
- s_data  in  DATA_W  stream word.
- s_valid  in  1  stream word valid.
- s_ready  out  1  equals busy AND (FIFO not full).
- user_start  out  1  one-cycle burst launch to the master.
- user_free  in  1  master idle.
- user_addr_in  out  ADDR_W  burst address.
- user_burst_len_in  out  8  burst beats minus 1.
- user_data_in  out  DATA_W  current write beat; always the FIFO head.
- user_data_strb  out  DATA_W/8  constant all-ones while busy.
- user_w_r  out  1  constant 0 (write).
- user_stall_w_data  in  1  master not accepting data this cycle.
- user_status  in  2  master response of the last burst (0 = OKAY).

## Operation
- States: IDLE, CALC, FILL, REQ, DATA, DRAIN, FIN.
- IDLE: on cfg_start, latch addr=cfg_base_addr and left=cfg_beats, clear err, go to CALC.
  - If cfg_beats==0, go to FIN directly; no bursts are issued.
- CALC: compute n = min(left, MAX_BURST, to_4k), then go to FILL.
  - to_4k = (4096 - addr[11:0]) / (DATA_W/8).
  - n is registered.
- FILL: wait until fifo_count >= n, then go to REQ.
- REQ: wait for user_free=1. Then drive user_start=1 for exactly one cycle, with user_addr_in=addr and user_burst_len_in=n-1. Go to DATA.
- DATA: the FIFO pops on each rising edge where user_stall_w_data=0. A beat counter counts pops.
  - After the n-th pop, go to DRAIN.
  - No pop occurs when the FIFO is empty. Cannot occur by construction; assertion-checked.
- DRAIN: wait for user_free=1.
  - Then sample user_status; nonzero sets err.
  - Update addr += n*(DATA_W/8) and left -= n.
  - If left==0, go to FIN; otherwise go to CALC.
- FIN: pulse done for one cycle, drop busy, return to IDLE.
- FIFO push and pop may occur in the same cycle; the count is unchanged.
- A push occurs only when s_valid && s_ready.
- Stream words beyond cfg_beats are not blocked but are not consumed by the current job. The bench must not send them.
- Address arithmetic wraps modulo 2^ADDR_W. No overflow detection.

## Timing
- Reset values: busy=0, done=0, err=0, s_ready=0, user_start=0, user_addr_in=0, user_burst_len_in=0, user_data_strb=0, user_w_r=0, FIFO empty, state IDLE.
- user_data_in is combinational from the FIFO head; it is 0 when empty.
- busy rises in the cycle after cfg_start.
- When the FIFO already holds n words and user_free=1: CALC takes 1 cycle, FILL 1 cycle, then user_start is asserted.
- user_start is never asserted in the cycle where user_free is first sampled low after a previous start. The master has a 1-cycle free-drop latency; DRAIN requires user_free to have been seen low at least once after user_start before accepting it high.
- done is asserted 1 cycle after the final DRAIN exit.
- Reset mid-job: all state is discarded immediately, the FIFO is flushed, and the master must also be reset.

## Configuration
- WRFEED_4K_SPLIT_EN defined: the to_4k term is included in CALC, so no burst crosses a 4 KB boundary.
- WRFEED_4K_SPLIT_EN undefined: n = min(left, MAX_BURST). Software guarantees that bursts do not cross 4 KB; the to_4k logic is absent.

## Test plan
- Basic job: base 0x10000000, 40 beats, stream continuous, user_status=0 → three bursts at 0x10000000/len 15, 0x10000080/len 15, 0x10000100/len 7; 40 pops in order; done pulse; err=0.
- 4K split (macro on): base 0x10000FC0, 16 beats → bursts 0x10000FC0/len 7 then 0x10001000/len 7. With the macro off → a single burst, len 15.
- Stalls: user_stall_w_data toggled 1 cycle on / 2 off during DATA → each word is presented until its pop; no duplicates or skips.
- Slow source: s_valid high only every 4th cycle, 20 beats → user_start for the first burst waits until the FIFO holds 16 words; data order is preserved.
- Error: master returns user_status=2 on the second of three bursts → err=1 at done, all three bursts still issued; next cfg_start clears err.
- Edge cases: cfg_beats=0 → done after 2 cycles, no user_start. aresetn low during DATA → all outputs at reset values asynchronously.
